// File: rtl/otprom_prog_ctrl_pkg.sv
// Shared constants for the OTP ROM programming controller: default bus
// widths, status codes and FSM state encodings.
package otprom_prog_ctrl_pkg;

  localparam int BUS_WIDTH  = 16;
  localparam int DATA_WIDTH = 32;

  // Completion status reported on prog_status; code 3 is reserved.
  typedef enum logic [1:0] {
    OTP_ST_OK       = 2'd0,
    OTP_ST_LOCKED   = 2'd1,
    OTP_ST_VFY_FAIL = 2'd2
  } otp_status_e;

  // Controller states. VFY/VCHK are only reachable when read-back verify
  // is compiled in.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RCHK = 3'd2,
    S_BURN = 3'd3,
    S_VFY  = 3'd4,
    S_VCHK = 3'd5,
    S_DONE = 3'd6
  } otp_state_e;

endpackage

// File: rtl/otprom_prog_ctrl_if.sv
// Programming-master port of the OTP ROM programming controller.
//
// Handshake: a request is accepted in the cycle where prog_valid and
// prog_ready are both high; prog_addr/prog_data/prog_lock must be stable
// in that cycle. prog_ready is high only while the controller is idle, and
// prog_valid seen while prog_ready is low is ignored. Completion is a
// one-cycle prog_done pulse; prog_status holds until the next completion.
interface otprom_prog_ctrl_if
  import otprom_prog_ctrl_pkg::*;
#(
  parameter int ADDR_W = BUS_WIDTH,
  parameter int DATA_W = DATA_WIDTH
);

  logic              prog_valid;
  logic              prog_ready;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_lock;
  logic              prog_done;
  logic [1:0]        prog_status;

  modport master (
    output prog_valid, prog_addr, prog_data, prog_lock,
    input  prog_ready, prog_done, prog_status
  );

  modport slave (
    input  prog_valid, prog_addr, prog_data, prog_lock,
    output prog_ready, prog_done, prog_status
  );

endinterface

// File: rtl/otp_burn_timer.sv
// Loadable down-counter that sets the OTP write-pulse width. Load wins over
// enable; the counter stops at zero.
module otp_burn_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // Next count: load, else decrement while enabled and nonzero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/otprom_prog_ctrl.sv
// OTP ROM programming (burn) controller. Takes one request at a time,
// reads the current word, burns only the 0->1 bits with a BURN_CYCLES-long
// write pulse and reports a status code.
// Optional feature: define OTPROM_PROG_VERIFY_EN to add a read-back verify
// after the burn (VFY/VCHK states, VERIFY_FAIL status).
module otprom_prog_ctrl
  import otprom_prog_ctrl_pkg::*;
#(
  parameter int ADDR_W      = BUS_WIDTH,
  parameter int DATA_W      = DATA_WIDTH,
  parameter int BURN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  otprom_prog_ctrl_if.slave   prog,
  output logic [ADDR_W-1:0]   ram_raddr,
  output logic                ram_ren,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wen,
  output otp_state_e          dbg_state
);

  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(BURN_CYCLES + 1);
  localparam logic [CW-1:0] BURN_LOAD = CW'(BURN_CYCLES - 1);

  otp_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  otp_status_e       status_q, status_d;
  logic [DATA_W-1:0] rd_mask;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [NB-1:0]     wen_dec;

  // Bits still to burn, based on the word read back in RCHK.
  assign rd_mask = data_q & ~ram_rdata;

  otp_burn_timer #(.W(CW)) u_burn_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (BURN_LOAD),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Next-state logic; the status register is loaded on the way into DONE
  // so it is already valid in the cycle prog_done pulses.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    old_d    = old_q;
    mask_d   = mask_q;
    status_d = status_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (prog.prog_valid) begin
          addr_d = prog.prog_addr;
          data_d = prog.prog_data;
          if (prog.prog_lock) begin
            status_d = OTP_ST_LOCKED;
            state_d  = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_RCHK;
      S_RCHK: begin
        old_d  = ram_rdata;
        mask_d = rd_mask;
        if (rd_mask == '0) begin
          status_d = OTP_ST_OK;
          state_d  = S_DONE;
        end else begin
          tmr_load = 1'b1;
          state_d  = S_BURN;
        end
      end
      S_BURN: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
`ifdef OTPROM_PROG_VERIFY_EN
          state_d = S_VFY;
`else
          status_d = OTP_ST_OK;
          state_d  = S_DONE;
`endif
        end
      end
`ifdef OTPROM_PROG_VERIFY_EN
      S_VFY: state_d = S_VCHK;
      S_VCHK: begin
        // Only requested 1s are checked; already-burned extras are fine.
        status_d = ((ram_rdata & data_q) == data_q) ? OTP_ST_OK : OTP_ST_VFY_FAIL;
        state_d  = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      old_q    <= '0;
      mask_q   <= '0;
      status_q <= OTP_ST_OK;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      old_q    <= old_d;
      mask_q   <= mask_d;
      status_q <= status_d;
    end
  end

  // Byte write enables: only bytes with something to burn, only in BURN.
  always_comb begin
    wen_dec = '0;
    for (int i = 0; i < NB; i++) begin
      wen_dec[i] = (state_q == S_BURN) && (mask_q[i*8 +: 8] != 8'h00);
    end
  end

  // All outputs decode registered state only.
  assign prog.prog_ready  = (state_q == S_IDLE);
  assign prog.prog_done   = (state_q == S_DONE);
  assign prog.prog_status = status_q;
  assign ram_ren          = (state_q == S_RD) || (state_q == S_VFY);
  assign ram_raddr        = addr_q;
  assign ram_waddr        = addr_q;
  assign ram_wdata        = (state_q == S_BURN) ? (old_q | data_q) : '0;
  assign ram_wen          = wen_dec;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_otprom_prog_ctrl.sv
// Self-checking bench for otprom_prog_ctrl: directed cases plus randomized
// requests against a behavioural OTP model. Expectations follow the
// OTPROM_PROG_VERIFY_EN setting of the build.
module tb_otprom_prog_ctrl;
  import otprom_prog_ctrl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int B  = 4;
`ifdef OTPROM_PROG_VERIFY_EN
  localparam bit VFY_EN = 1'b1;
`else
  localparam bit VFY_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  otprom_prog_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) pif ();

  logic [AW-1:0]   ram_raddr, ram_waddr;
  logic            ram_ren;
  logic [DW-1:0]   ram_rdata = '0;
  logic [DW-1:0]   ram_wdata;
  logic [DW/8-1:0] ram_wen;
  otp_state_e      dbg_state;

  otprom_prog_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURN_CYCLES(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog      (pif),
    .ram_raddr (ram_raddr),
    .ram_ren   (ram_ren),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .dbg_state (dbg_state)
  );

  // ---------------- OTP RAM model ----------------
  logic [DW-1:0] mem [int];
  bit drop_b4 = 1'b0;

  function automatic logic [DW-1:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  always @(posedge clk) begin : ram_model
    logic [DW-1:0] w;
    if (ram_ren) ram_rdata <= mem_rd(int'(ram_raddr));
    if (|ram_wen) begin
      w = mem_rd(int'(ram_waddr));
      for (int i = 0; i < DW/8; i++)
        if (ram_wen[i]) w[i*8 +: 8] = ram_wdata[i*8 +: 8];
      if (drop_b4) w[4] = 1'b0;
      mem[int'(ram_waddr)] = w;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_miss = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at #1 after a posedge. Issues one request and checks everything
  // observable up to one cycle after completion.
  task automatic run_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit lk);
    logic [DW-1:0] old, mask, stored, exp_wen;
    int exp_lat, exp_stat, exp_ren, k, wen_cyc, ren_cyc, overlap, first_wen;
    bit burn, done_seen;

    // reference: derived from the word currently in the OTP
    old  = mem_rd(int'(a));
    mask = d & ~old;
    burn = !lk && (mask != '0);
    stored = old | d;
    if (drop_b4) stored[4] = 1'b0;
    exp_wen = '0;
    for (int i = 0; i < DW/8; i++) exp_wen[i] = (mask[i*8 +: 8] != 0);
    if (lk) begin
      exp_lat = 1; exp_stat = 1; exp_ren = 0;
    end else if (!burn) begin
      exp_lat = 3; exp_stat = 0; exp_ren = 1;
    end else if (VFY_EN) begin
      exp_lat = 5 + B; exp_ren = 2;
      exp_stat = ((stored & d) == d) ? 0 : 2;
    end else begin
      exp_lat = 3 + B; exp_stat = 0; exp_ren = 1;
    end
    exp_q.delete();
    if (burn) for (int i = 0; i < B; i++) exp_q.push_back(exp_wen);

    for (int i = 0; i < 20 && !pif.prog_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!pif.prog_ready) begin
      check("ready_wait", 0, 1);
      return;
    end

    pif.prog_valid = 1'b1;
    pif.prog_addr  = a;
    pif.prog_data  = d;
    pif.prog_lock  = lk;
    wen_cyc = 0; ren_cyc = 0; overlap = 0; first_wen = 0; done_seen = 1'b0; k = 0;
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      @(posedge clk); #1;
      k = c;
      pif.prog_valid = 1'b0;
      pif.prog_lock  = $urandom_range(0, 1);
      if (ram_ren) ren_cyc++;
      if (ram_ren && (|ram_wen)) overlap++;
      if (|ram_wen) begin
        wen_cyc++;
        if (first_wen == 0) first_wen = c;
        if (exp_q.size() > 0) check("wen", ram_wen, exp_q.pop_front());
        else check("wen_extra", ram_wen, 0);
        check("wdata", ram_wdata, old | d);
      end
      if (pif.prog_done) begin
        done_seen = 1'b1;
        check("status", pif.prog_status, exp_stat);
      end
    end
    if (!done_seen) check("done_timeout", 0, 1);
    else check("done_lat", k, exp_lat);
    check("wen_cycles", wen_cyc, burn ? B : 0);
    if (burn) check("wen_start", first_wen, 3);
    check("wen_missing", exp_q.size(), 0);
    check("ren_cycles", ren_cyc, exp_ren);
    check("ren_wen_overlap", overlap, 0);
    exp_q.delete();

    @(posedge clk); #1;
    check("done_pulse", pif.prog_done, 0);
    check("ready_after", pif.prog_ready, 1);
    check("status_hold", pif.prog_status, exp_stat);
    if (burn && !drop_b4) check("mem", mem_rd(int'(a)), old | d);
    if (lk) check("mem_lock", mem_rd(int'(a)), old);
  endtask

  // Reset during the second burn cycle, then a normal request.
  task automatic reset_mid_burn();
    int dn;
    mem[32'h40] = '0;
    pif.prog_valid = 1'b1;
    pif.prog_addr  = 16'h0040;
    pif.prog_data  = 32'h0000_0100;
    pif.prog_lock  = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      pif.prog_valid = 1'b0;
    end
    check("rst_pre_wen", ram_wen, 4'b0010);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_wen", ram_wen, 0);
    check("rst_ready", pif.prog_ready, 1);
    check("rst_done", pif.prog_done, 0);
    reset = 1'b0;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (pif.prog_done) dn++;
    end
    check("rst_no_done", dn, 0);
    run_req(16'h0041, 32'h0300_0000, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    pif.prog_valid = 1'b0;
    pif.prog_addr  = '0;
    pif.prog_data  = '0;
    pif.prog_lock  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", pif.prog_ready, 1);
    check("rst_done0", pif.prog_done, 0);
    check("rst_status0", pif.prog_status, 0);
    check("rst_ren0", ram_ren, 0);
    check("rst_wen0", ram_wen, 0);
    check("rst_raddr0", ram_raddr, 0);
    check("rst_waddr0", ram_waddr, 0);
    check("rst_wdata0", ram_wdata, 0);
    check("rst_state0", dbg_state, S_IDLE);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed cases
    mem[32'h10] = 32'h0;
    run_req(16'h0010, 32'h0000_0001, 1'b0);
    mem[32'h20] = 32'h0000_00FF;
    run_req(16'h0020, 32'h0000_FF0F, 1'b0);
    mem[32'h30] = 32'h0000_000F;
    run_req(16'h0030, 32'h0000_0003, 1'b0);
    mem[32'h50] = 32'h0;
    run_req(16'h0050, 32'h0000_00FF, 1'b1);
    drop_b4 = 1'b1;
    mem[32'h60] = 32'h0;
    run_req(16'h0060, 32'h0000_0010, 1'b0);
    drop_b4 = 1'b0;
    reset_mid_burn();

    // randomized requests over a small address window
    for (int a = 0; a < 16; a++) mem[a] = $urandom & $urandom;
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 1) == 1) ? ($urandom & $urandom & $urandom) : $urandom;
      drop_b4 = ($urandom_range(0, 5) == 0);
      run_req(16'($urandom_range(0, 15)), d, ($urandom_range(0, 7) == 0));
      drop_b4 = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
